// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin decode arbiter: FSM encoding,
// default sizing and the rotate-priority search helper.
package arb_pkg;

  localparam int DEF_N        = 8;
  localparam int DEF_MAX_HOLD = 16;
  localparam int PICK_W       = 16;  // widest request vector the helper handles

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // First set request at or after (last+1) mod n, searching upward with wrap.
  // Returns 0 when nothing is requested; callers only use it when |req.
  function automatic logic [3:0] rr_pick(input logic [PICK_W-1:0] req,
                                         input logic [3:0]        last,
                                         input int                n);
    logic [3:0] win;
    logic       found;
    int         c;
    win   = 4'd0;
    found = 1'b0;
    for (int i = 1; i <= PICK_W; i++) begin
      c = (int'(last) + i) % n;
      if ((i <= n) && !found && req[c[3:0]]) begin
        win   = c[3:0];
        found = 1'b1;
      end else begin
        win   = win;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface rr_decode_arbiter_if
  import arb_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int IDXW = $clog2(N)
) ();

  logic            en;
  logic [N-1:0]    req;
  logic            done;
  logic [N-1:0]    gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_valid;
  logic            timeout;

  // Requester side
  modport master (
    output en, req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  // Arbiter side
  modport slave (
    input  en, req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );

endinterface

// File: rtl/rr_decode_arbiter_grant_decoder.sv
// Enabled binary-to-one-hot decoder built as a tree of 1-to-2 enabled stages.
// Each level splits every live enable on one index bit, MSB first, so leaf j
// is reached exactly when idx == j.
module grant_decoder
  import arb_pkg::*;
#(
  parameter int IDXW = 3,
  parameter int N    = 8
) (
  input  logic [IDXW-1:0] idx,
  input  logic            en,
  output logic [N-1:0]    onehot
);

  // Walk the enable down the tree level by level.
  always_comb begin
    logic [IDXW:0][N-1:0] lvl;
    lvl       = '0;
    lvl[0][0] = en;
    for (int l = 0; l < IDXW; l++) begin
      for (int k = 0; k < (1 << l); k++) begin
        lvl[l+1][2*k]   = lvl[l][k] & ~idx[IDXW-1-l];
        lvl[l+1][2*k+1] = lvl[l][k] &  idx[IDXW-1-l];
      end
    end
    onehot = lvl[IDXW];
  end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter sharing one decoded-enable resource among N requesters.
// IDLE arbitrates, GRANT holds the owner until release or hold timeout,
// RELEASE inserts a break-before-make dead cycle.
module rr_decode_arbiter
  import arb_pkg::*;
#(
  parameter int N        = DEF_N,
  parameter int IDXW     = $clog2(N),
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input logic                clk,
  input logic                rst_n,
  rr_decode_arbiter_if.slave bus
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t        state_r;
  arb_state_t        state_nxt_s;
  logic [HW-1:0]     hold_cnt_r;
  logic [IDXW-1:0]   last_ptr_r;
  logic [IDXW-1:0]   gnt_idx_r;
  logic              gnt_valid_r;
  logic              timeout_r;

  logic [PICK_W-1:0] req_ext_s;
  logic [IDXW-1:0]   win_s;
  logic              any_req_s;
  logic              owner_req_s;
  logic              hold_max_s;
  logic              exit_s;
  logic              timeout_only_s;
  logic [N-1:0]      gnt_s;

  // Rotate-priority winner and grant-exit conditions.
  always_comb begin
    req_ext_s          = '0;
    req_ext_s[N-1:0]   = bus.req;
    win_s              = IDXW'(rr_pick(req_ext_s, 4'(last_ptr_r), N));
    any_req_s          = |bus.req;
    owner_req_s        = bus.req[gnt_idx_r];
    hold_max_s         = (hold_cnt_r == HW'(MAX_HOLD));
    exit_s             = bus.done | ~owner_req_s | ~bus.en | hold_max_s;
    // Any voluntary reason for exit in the same cycle suppresses the pulse.
    timeout_only_s     = hold_max_s & ~bus.done & owner_req_s & bus.en;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.en && any_req_s) begin
          state_nxt_s = ST_GRANT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (exit_s) begin
          state_nxt_s = ST_RELEASE;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_RELEASE: state_nxt_s = ST_IDLE;
      default:    state_nxt_s = ST_IDLE;
    endcase
  end

  // Registered outputs, hold counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_idx_r   <= '0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= '0;
      last_ptr_r  <= IDXW'(N - 1);
    end else begin
      case (state_r)
        ST_IDLE: begin
          timeout_r <= 1'b0;
          if (bus.en && any_req_s) begin
            gnt_idx_r   <= win_s;
            gnt_valid_r <= 1'b1;
            hold_cnt_r  <= HW'(1);
          end else begin
            gnt_valid_r <= 1'b0;
            hold_cnt_r  <= '0;
          end
        end
        ST_GRANT: begin
          if (exit_s) begin
            last_ptr_r  <= gnt_idx_r;
            gnt_valid_r <= 1'b0;
            hold_cnt_r  <= '0;
            timeout_r   <= timeout_only_s;
          end else begin
            hold_cnt_r  <= hold_cnt_r + HW'(1);
            timeout_r   <= 1'b0;
          end
        end
        ST_RELEASE: begin
          gnt_valid_r <= 1'b0;
          timeout_r   <= 1'b0;
          hold_cnt_r  <= '0;
        end
        default: begin
          gnt_valid_r <= 1'b0;
          timeout_r   <= 1'b0;
          hold_cnt_r  <= '0;
        end
      endcase
    end
  end

  grant_decoder #(
    .IDXW (IDXW),
    .N    (N)
  ) u_grant_decoder (
    .idx    (gnt_idx_r),
    .en     (gnt_valid_r),
    .onehot (gnt_s)
  );

  assign bus.gnt       = gnt_s;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule
